// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the command-driven counter sequencer.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  localparam logic [7:0] RESET_VAL_DEFAULT = 8'd20;

endpackage

// File: rtl/counter_seq_dp.sv
// Counter datapath: count register with load/clear/increment and wrap flag.
// COUNTER_SEQ_SAT_EN: saturate at max and make wrap a sticky saturation flag.
module counter_seq_dp #(
  parameter int unsigned        WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             clear_en,
  input  logic             inc_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic at_max;
  assign at_max = (count == '1);

`ifdef COUNTER_SEQ_SAT_EN
  // Saturating counter; wrap latches on the first clipped step until LOAD/CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_VAL;
      wrap  <= 1'b0;
    end else begin
      if (load_en) begin
        count <= load_val;
        wrap  <= 1'b0;
      end else if (clear_en) begin
        count <= RESET_VAL;
        wrap  <= 1'b0;
      end else if (inc_en) begin
        if (at_max) begin
          wrap <= 1'b1;
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
  end
`else
  // Modulo counter; wrap pulses in the cycle that shows the wrapped value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_VAL;
      wrap  <= 1'b0;
    end else begin
      wrap <= inc_en && at_max;
      if (load_en) begin
        count <= load_val;
      end else if (clear_en) begin
        count <= RESET_VAL;
      end else if (inc_en) begin
        count <= count + WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command sequencer FSM (IDLE/RUN/DONE) driving the counter datapath.
// COUNTER_SEQ_SAT_EN selects saturating arithmetic in counter_seq_dp.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] remain_q, remain_d;
  logic             load_en, clear_en, inc_en;

  // State and step-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  // Next-state and datapath controls; abort takes priority over the final step.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    load_en  = 1'b0;
    clear_en = 1'b0;
    inc_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_LOAD:  load_en  = 1'b1;
            OP_CLEAR: clear_en = 1'b1;
            OP_RUN: begin
              if (cmd_data != '0) begin
                remain_d = cmd_data;
                state_d  = ST_RUN;
              end else begin
                state_d  = ST_DONE;
              end
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          inc_en   = 1'b1;
          remain_d = remain_q - WIDTH'(1);
          if (remain_q == WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

  counter_seq_dp #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .clear_en (clear_en),
    .inc_en   (inc_en),
    .load_val (cmd_data),
    .count    (count_out),
    .wrap     (wrap)
  );

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl; models both modulo and saturating builds.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       abort;
  logic [7:0] count_out;
  logic       busy, done, wrap;

  typedef struct packed {
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       ready;
  } exp_t;

  exp_t       sb[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] m_count;
  logic       m_wrap;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  counter_seq_ctrl #(
    .WIDTH     (8),
    .RESET_VAL (8'd20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .count_out (count_out),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) until ready, then return 1ns after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    while (!cmd_ready && waited < 64) begin
      tick();
      waited++;
    end
    if (!cmd_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
    end
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic pop_check(input string name);
    exp_t e, a;
    e = sb.pop_front();
    a = '{cnt: count_out, busy: busy, done: done, wrap: wrap, ready: cmd_ready};
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got cnt=%h busy=%b done=%b wrap=%b rdy=%b, want cnt=%h busy=%b done=%b wrap=%b rdy=%b",
               name, a.cnt, a.busy, a.done, a.wrap, a.ready, e.cnt, e.busy, e.done, e.wrap, e.ready);
    end
  endtask

  task automatic model_load(input logic [7:0] v);
    m_count = v;
`ifdef COUNTER_SEQ_SAT_EN
    m_wrap = 1'b0;
`endif
  endtask

  function automatic logic idle_wrap();
`ifdef COUNTER_SEQ_SAT_EN
    return m_wrap;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_load(input logic [1:0] op, input logic [7:0] v);
    issue(op, v);
    model_load(op == OP_CLEAR ? 8'd20 : v);
    sb.push_back('{cnt: m_count, busy: 1'b0, done: 1'b0, wrap: idle_wrap(), ready: 1'b1});
    pop_check(op == OP_CLEAR ? "clear" : "load");
  endtask

  // RUN n steps; abort_cyc >= 0 raises abort during that cycle after the accept edge.
  task automatic do_run(input string name, input logic [7:0] n, input int abort_cyc);
    logic w;
    int   idx;
    issue(OP_RUN, n);
    w = idle_wrap();
    if (n == 0) begin
      sb.push_back('{cnt: m_count, busy: 1'b0, done: 1'b1, wrap: w, ready: 1'b0});
    end else begin
      sb.push_back('{cnt: m_count, busy: 1'b1, done: 1'b0, wrap: w, ready: 1'b0});
      for (int k = 1; k <= int'(n); k++) begin
        if (abort_cyc == k - 1) begin
          break;
        end
`ifdef COUNTER_SEQ_SAT_EN
        if (m_count == 8'hFF) m_wrap = 1'b1;
        else                  m_count = m_count + 8'd1;
        w = m_wrap;
`else
        w = (m_count == 8'hFF);
        m_count = m_count + 8'd1;
`endif
        sb.push_back('{cnt: m_count, busy: (k < int'(n)), done: (k == int'(n)), wrap: w, ready: 1'b0});
      end
    end
    sb.push_back('{cnt: m_count, busy: 1'b0, done: 1'b0, wrap: idle_wrap(), ready: 1'b1});
    idx = 0;
    while (sb.size() > 0) begin
      pop_check(name);
      if (sb.size() > 0) begin
        if (idx == abort_cyc) abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      idx++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    m_count = 8'd20;
    m_wrap  = 1'b0;
    sb.push_back('{cnt: 8'd20, busy: 1'b0, done: 1'b0, wrap: 1'b0, ready: 1'b1});
    pop_check("reset_held");
    rst = 1'b0;
    tick();
    sb.push_back('{cnt: 8'd20, busy: 1'b0, done: 1'b0, wrap: 1'b0, ready: 1'b1});
    pop_check("reset_release");
  endtask

  task automatic test_run_basic();
    do_load(OP_LOAD, 8'h10);
    do_run("run5", 8'd5, -1);
    do_load(OP_LOAD, 8'hFE);
    do_run("run_wrap", 8'd3, -1);
    do_run("run_zero", 8'd0, -1);
    do_load(OP_LOAD, 8'h05);
    do_run("run255", 8'd255, -1);
  endtask

  task automatic test_abort();
    do_load(OP_LOAD, 8'h40);
    do_run("abort_mid", 8'd10, 2);
    do_load(OP_LOAD, 8'h60);
    do_run("abort_final", 8'd4, 3);
  endtask

  // CLEAR held valid through a RUN must wait for IDLE, then apply once.
  task automatic test_held_clear();
    do_load(OP_LOAD, 8'h30);
    cmd_valid = 1'b1;
    cmd_op    = OP_RUN;
    cmd_data  = 8'd3;
    tick();
    cmd_op = OP_CLEAR;
    sb.push_back('{cnt: 8'h30, busy: 1'b1, done: 1'b0, wrap: 1'b0, ready: 1'b0});
    sb.push_back('{cnt: 8'h31, busy: 1'b1, done: 1'b0, wrap: 1'b0, ready: 1'b0});
    sb.push_back('{cnt: 8'h32, busy: 1'b1, done: 1'b0, wrap: 1'b0, ready: 1'b0});
    sb.push_back('{cnt: 8'h33, busy: 1'b0, done: 1'b1, wrap: 1'b0, ready: 1'b0});
    sb.push_back('{cnt: 8'h33, busy: 1'b0, done: 1'b0, wrap: 1'b0, ready: 1'b1});
    sb.push_back('{cnt: 8'd20, busy: 1'b0, done: 1'b0, wrap: 1'b0, ready: 1'b1});
    while (sb.size() > 0) begin
      pop_check("held_clear");
      if (sb.size() == 0) cmd_valid = 1'b0;
      if (sb.size() > 0) tick();
    end
    model_load(8'd20);
    tick();
    sb.push_back('{cnt: 8'd20, busy: 1'b0, done: 1'b0, wrap: 1'b0, ready: 1'b1});
    pop_check("held_clear_after");
  endtask

  // One LOAD/CLEAR/NOP per clock with valid held continuously.
  task automatic test_back_to_back();
    logic [1:0] ops [5] = '{OP_LOAD, OP_LOAD, OP_NOP, OP_CLEAR, OP_LOAD};
    logic [7:0] vals[5] = '{8'hA5, 8'h3C, 8'hEE, 8'h99, 8'h7F};
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_op   = ops[i];
      cmd_data = vals[i];
      tick();
      if (ops[i] == OP_LOAD)  model_load(vals[i]);
      if (ops[i] == OP_CLEAR) model_load(8'd20);
      sb.push_back('{cnt: m_count, busy: 1'b0, done: 1'b0, wrap: idle_wrap(), ready: 1'b1});
      pop_check("b2b");
    end
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic test_reset_mid_run();
    do_load(OP_LOAD, 8'h10);
    issue(OP_RUN, 8'd10);
    tick();
    tick();
    rst = 1'b1;
    #1;
    model_load(8'd20);
    m_wrap = 1'b0;
    sb.push_back('{cnt: 8'd20, busy: 1'b0, done: 1'b0, wrap: 1'b0, ready: 1'b1});
    pop_check("reset_mid_run");
    tick();
    rst = 1'b0;
    tick();
    sb.push_back('{cnt: 8'd20, busy: 1'b0, done: 1'b0, wrap: 1'b0, ready: 1'b1});
    pop_check("reset_mid_run_release");
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = '0;
    abort     = 1'b0;
    test_reset();
    test_run_basic();
    test_abort();
    test_held_clear();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
